// File: rtl/apb_pkg.sv
// Shared types and defaults for the parametrised APB4 master.
// State encoding and select-width helper used by apb_master_mux.
package apb_pkg;

  localparam int APB_STATE_W = 2;
  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_NUM_SLV = 4;
  localparam int APB_TMO_DEF = 16;

  typedef enum logic [APB_STATE_W-1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave select decoder: upper address field -> one-hot PSEL pattern.
// Indices at or beyond NUM_SLAVES flag a decode error and select nothing.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = APB_NUM_SLV,
  parameter int SEL_BITS   = sel_bits(APB_NUM_SLV)
) (
  input  logic [SEL_BITS-1:0]   i_idx,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_dec_err
);

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_sel[i] = (i_idx == SEL_BITS'(i));
    end
    o_dec_err = ({1'b0, i_idx} >= (SEL_BITS+1)'(NUM_SLAVES));
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB4 master: valid/ready request in, SETUP/ACCESS to NUM_SLAVES, response out.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states by TIMEOUT_CYCLES.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_W,
  parameter int DATA_WIDTH     = APB_DATA_W,
  parameter int NUM_SLAVES     = APB_NUM_SLV,
  parameter int TIMEOUT_CYCLES = APB_TMO_DEF
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [DATA_WIDTH/8-1:0]        req_strb,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  output logic [NUM_SLAVES-1:0]          PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDR_WIDTH-1:0]          PADDR,
  output logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH/8-1:0]        PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]          PREADY,
  input  logic [NUM_SLAVES-1:0]          PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_BITS   = sel_bits(NUM_SLAVES);

  apb_state_e              r_state, w_state_nxt;
  logic [SEL_BITS-1:0]     r_idx, w_idx_nxt;
  logic                    r_dec_err, w_dec_err_nxt;
  logic [NUM_SLAVES-1:0]   r_psel, w_psel_nxt;
  logic                    r_penable, w_penable_nxt;
  logic                    r_pwrite, w_pwrite_nxt;
  logic [ADDR_WIDTH-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_WIDTH-1:0]   r_pwdata, w_pwdata_nxt;
  logic [STRB_WIDTH-1:0]   r_pstrb, w_pstrb_nxt;
  logic                    r_req_ready, w_req_ready_nxt;
  logic                    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                    r_rsp_err, w_rsp_err_nxt;
`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0]              r_cnt, w_cnt_nxt;
`endif

  logic [SEL_BITS-1:0]     w_dec_idx;
  logic [NUM_SLAVES-1:0]   w_dec_sel;
  logic                    w_dec_err;
  logic                    w_ready;
  logic                    w_slverr;
  logic [DATA_WIDTH-1:0]   w_prdata;

  assign w_dec_idx = req_addr[ADDR_WIDTH-1 -: SEL_BITS];

  apb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_BITS   (SEL_BITS)
  ) u_dec (
    .i_idx     (w_dec_idx),
    .o_sel     (w_dec_sel),
    .o_dec_err (w_dec_err)
  );

  // Only the latched slave's ready/error/data lanes are ever looked at.
  always_comb begin
    w_ready  = 1'b0;
    w_slverr = 1'b0;
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_idx == SEL_BITS'(i)) begin
        w_ready  = PREADY[i];
        w_slverr = PSLVERR[i];
        w_prdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_dec_err_nxt   = r_dec_err;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_pstrb_nxt     = r_pstrb;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    w_cnt_nxt       = r_cnt;
`endif
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_nxt     = SETUP;
          w_req_ready_nxt = 1'b0;
          w_idx_nxt       = w_dec_idx;
          w_dec_err_nxt   = w_dec_err;
          w_pwrite_nxt    = req_write;
          w_paddr_nxt     = req_addr;
          w_pwdata_nxt    = req_wdata;
          if (!w_dec_err) begin
            w_psel_nxt  = w_dec_sel;
            w_pstrb_nxt = req_write ? req_strb : '0;
          end
        end
      end
      // Decode errors spend this cycle with PSEL low, then answer.
      SETUP: begin
        if (r_dec_err) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_state_nxt   = ACCESS;
          w_penable_nxt = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          w_cnt_nxt     = 8'd0;
`endif
        end
      end
      ACCESS: begin
        if (w_ready) begin
          w_state_nxt     = RESP;
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_pstrb_nxt     = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = w_slverr;
          w_rsp_rdata_nxt = (!r_pwrite && !w_slverr) ? w_prdata : '0;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt     = RESP;
          w_psel_nxt      = '0;
          w_penable_nxt   = 1'b0;
          w_pstrb_nxt     = '0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_req_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_dec_err   <= 1'b0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_cnt       <= 8'd0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dec_err   <= w_dec_err_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pstrb     <= w_pstrb_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
`ifdef APB_MASTER_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
`endif
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: 4-slave instance plus a 3-slave
// instance whose top select index is unmapped (decode error path).
module tb_apb_master_mux;

  logic         PCLK = 1'b0;
  logic         PRESETn;
  logic         req_valid, req_ready, req_write;
  logic [31:0]  req_addr, req_wdata;
  logic [3:0]   req_strb;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [31:0]  PADDR, PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  logic         req_valid3, req_ready3;
  logic         rsp_valid3, rsp_ready3, rsp_err3;
  logic [31:0]  rsp_rdata3;
  logic [2:0]   PSEL3;
  logic         PENABLE3, PWRITE3;
  logic [31:0]  PADDR3, PWDATA3;
  logic [3:0]   PSTRB3;
  logic [95:0]  PRDATA3;
  logic [2:0]   PREADY3, PSLVERR3;

  int n_chk = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  apb_master_mux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_mux #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)
  ) u_dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3), .PADDR(PADDR3),
    .PWDATA(PWDATA3), .PSTRB(PSTRB3), .PRDATA(PRDATA3),
    .PREADY(PREADY3), .PSLVERR(PSLVERR3)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    req_valid = 1'b1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    PRESETn    = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_strb   = '0;
    rsp_ready  = 1'b1;
    PRDATA     = '0;
    PREADY     = '0;
    PSLVERR    = '0;
    req_valid3 = 1'b0;
    rsp_ready3 = 1'b0;
    PRDATA3    = '0;
    PREADY3    = 3'b111;
    PSLVERR3   = '0;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pstrb", 32'(PSTRB), 32'd0);
    PRESETn = 1'b1;
    tick();

    // write to slave 2, zero wait states
    PREADY = 4'b0100;
    PRDATA[64 +: 32] = 32'hFFFF_FFFF;
    send(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("wr_setup_psel", 32'(PSEL), 32'h4);
    chk("wr_setup_pen", 32'(PENABLE), 32'd0);
    chk("wr_setup_paddr", PADDR, 32'h8000_0010);
    chk("wr_setup_pwdata", PWDATA, 32'hDEAD_BEEF);
    chk("wr_setup_pstrb", 32'(PSTRB), 32'hF);
    chk("wr_setup_pwrite", 32'(PWRITE), 32'd1);
    chk("wr_setup_rdy", 32'(req_ready), 32'd0);
    tick();
    chk("wr_acc_psel", 32'(PSEL), 32'h4);
    chk("wr_acc_pen", 32'(PENABLE), 32'd1);
    chk("wr_acc_rspv", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr_rsp_psel", 32'(PSEL), 32'd0);
    chk("wr_rsp_pen", 32'(PENABLE), 32'd0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("wr_idle_rspv", 32'(rsp_valid), 32'd0);
    chk("wr_idle_rdy", 32'(req_ready), 32'd1);
    chk("wr_idle_pstrb", 32'(PSTRB), 32'd0);
    chk("wr_idle_paddr", PADDR, 32'h8000_0010);

    // read slave 1 with three wait states; slave 0 ready is ignored
    PREADY = 4'b0001;
    PRDATA[0 +: 32]  = 32'hBAD0_0000;
    PRDATA[32 +: 32] = 32'h1234_5678;
    send(1'b0, 32'h4000_0004, 32'h0, 4'hF);
    chk("rd_setup_psel", 32'(PSEL), 32'h2);
    chk("rd_setup_pstrb", 32'(PSTRB), 32'd0);
    chk("rd_setup_pwrite", 32'(PWRITE), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_pen", 32'(PENABLE), 32'd1);
      chk("rd_wait_paddr", PADDR, 32'h4000_0004);
      chk("rd_wait_psel", 32'(PSEL), 32'h2);
      tick();
    end
    PREADY = 4'b0011;
    chk("rd_last_pen", 32'(PENABLE), 32'd1);
    chk("rd_last_rspv", 32'(rsp_valid), 32'd0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    chk("rd_rsp_psel", 32'(PSEL), 32'd0);
    tick();

    // read slave 3 while slave 0 raises PSLVERR
    PSLVERR = 4'b0001;
    PREADY  = 4'b1000;
    PRDATA[96 +: 32] = 32'hCAFE_F00D;
    send(1'b0, 32'hC000_0000, 32'h0, 4'h0);
    tick();
    tick();
    chk("unsel_err_rsp", 32'(rsp_err), 32'd0);
    chk("unsel_err_data", rsp_rdata, 32'hCAFE_F00D);
    tick();

    // read slave 3 with its own PSLVERR
    PSLVERR = 4'b1001;
    send(1'b0, 32'hC000_0000, 32'h0, 4'h0);
    tick();
    tick();
    chk("slverr_valid", 32'(rsp_valid), 32'd1);
    chk("slverr_err", 32'(rsp_err), 32'd1);
    chk("slverr_rdata", rsp_rdata, 32'd0);
    tick();
    PSLVERR = '0;

    // decode error on the 3-slave instance, response held off 5 cycles
    req_write  = 1'b0;
    req_addr   = 32'hC000_0000;
    req_valid3 = 1'b1;
    chk("dec_req_ready", 32'(req_ready3), 32'd1);
    tick();
    req_valid3 = 1'b0;
    chk("dec_n1_psel", 32'(PSEL3), 32'd0);
    chk("dec_n1_rspv", 32'(rsp_valid3), 32'd0);
    tick();
    chk("dec_n2_rspv", 32'(rsp_valid3), 32'd1);
    chk("dec_n2_err", 32'(rsp_err3), 32'd1);
    chk("dec_n2_rdata", rsp_rdata3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("dec_hold_rspv", 32'(rsp_valid3), 32'd1);
      chk("dec_hold_err", 32'(rsp_err3), 32'd1);
      chk("dec_hold_rdy", 32'(req_ready3), 32'd0);
      chk("dec_hold_psel", 32'(PSEL3), 32'd0);
      tick();
    end
    rsp_ready3 = 1'b1;
    chk("dec_final_rspv", 32'(rsp_valid3), 32'd1);
    tick();
    chk("dec_done_rspv", 32'(rsp_valid3), 32'd0);
    chk("dec_done_rdy", 32'(req_ready3), 32'd1);

    // reset during ACCESS
    PREADY = '0;
    send(1'b1, 32'h0000_0100, 32'h5555_AAAA, 4'h5);
    tick();
    chk("rst_acc_pen", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    tick();
    chk("rst_mid_psel", 32'(PSEL), 32'd0);
    chk("rst_mid_pen", 32'(PENABLE), 32'd0);
    chk("rst_mid_paddr", PADDR, 32'd0);
    chk("rst_mid_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_mid_rdy", 32'(req_ready), 32'd1);
    chk("rst_mid_rspv", 32'(rsp_valid), 32'd0);
    PRESETn = 1'b1;
    tick();
    chk("rst_after_rspv", 32'(rsp_valid), 32'd0);

    // slave 1 never ready
    PREADY = '0;
    send(1'b0, 32'h4000_0000, 32'h0, 4'h0);
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("tmo_wait_pen", 32'(PENABLE), 32'd1);
      chk("tmo_wait_psel", 32'(PSEL), 32'h2);
      tick();
    end
    chk("tmo_psel", 32'(PSEL), 32'd0);
    chk("tmo_pen", 32'(PENABLE), 32'd0);
    chk("tmo_rspv", 32'(rsp_valid), 32'd1);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    chk("tmo_rdata", rsp_rdata, 32'd0);
    tick();
`else
    for (int i = 0; i < 100; i++) tick();
    chk("nowait_pen", 32'(PENABLE), 32'd1);
    chk("nowait_psel", 32'(PSEL), 32'h2);
    chk("nowait_rspv", 32'(rsp_valid), 32'd0);
    PRESETn = 1'b0;
    tick();
    PRESETn = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
